// File: rtl/bus_pkg.sv
// Shared bus definitions: ID field width, broadcast ID and the packet ID extractor.
// Used by the receive endpoint, the driver-side FIFO and bench transaction code.
package bus_pkg;

    localparam int ID_W = 8;
    localparam logic [ID_W-1:0] BROADCAST_ID = 8'hFF;
    localparam int PKT_MAX_W = 64;

    // The ID occupies the top ID_W bits of a pkt_w-wide packet.
    function automatic logic [ID_W-1:0] pkt_id(input logic [PKT_MAX_W-1:0] pkt,
                                               input int unsigned pkt_w);
        return ID_W'(pkt >> (pkt_w - ID_W));
    endfunction

endpackage

// File: rtl/bus_rx_endpoint_if.sv
// Bus delivery (push/D_push) plus consumer valid/ready read port of the receive endpoint.
interface bus_rx_endpoint_if #(
    parameter int pckg_sz = 16
);
    logic               push;
    logic [pckg_sz-1:0] D_push;
    logic               rd_valid;
    logic               rd_ready;
    logic [pckg_sz-1:0] rd_data;

    modport master (output push, D_push, rd_ready, input rd_valid, rd_data);
    modport slave  (input push, D_push, rd_ready, output rd_valid, rd_data);
endinterface

// File: rtl/bus_rx_endpoint_fifo.sv
// Generic show-ahead FIFO: rd_data always shows the entry at the read pointer.
// Writes are refused when full unless a pop happens in the same cycle.
module rx_sync_fifo #(
    parameter int pckg_sz   = 16,
    parameter int deep_fifo = 8
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       wr_en,
    input  logic [pckg_sz-1:0]         wr_data,
    input  logic                       rd_en,
    output logic [pckg_sz-1:0]         rd_data,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(deep_fifo):0] count
);
    localparam int AW = $clog2(deep_fifo);
    localparam int CW = AW + 1;

    logic [pckg_sz-1:0] mem [deep_fifo];
    logic [AW-1:0]      wr_ptr_reg;
    logic [AW-1:0]      rd_ptr_reg;
    logic [CW-1:0]      count_reg;
    logic               do_wr;
    logic               do_rd;

    assign empty   = (count_reg == '0);
    assign full    = (count_reg == CW'(deep_fifo));
    assign count   = count_reg;
    assign rd_data = mem[rd_ptr_reg];

    assign do_rd = rd_en & ~empty;
    assign do_wr = wr_en & (~full | do_rd);

    // Storage carries no reset; only the pointers define what is valid.
    always_ff @(posedge clk) begin
        if (do_wr)
            mem[wr_ptr_reg] <= wr_data;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (do_wr)
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (do_rd)
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            if (do_wr && !do_rd)
                count_reg <= count_reg + 1'b1;
            else if (do_rd && !do_wr)
                count_reg <= count_reg - 1'b1;
        end
    end
endmodule

// File: rtl/bus_rx_endpoint.sv
// Device-side bus receive endpoint: address filter, show-ahead receive FIFO, sticky overflow.
// Optional BUS_RX_STATS_EN adds saturating rx/drop counters.
module bus_rx_endpoint
    import bus_pkg::*;
#(
    parameter int        pckg_sz   = 16,
    parameter int        deep_fifo = 8,
    parameter logic [7:0] drvr_id  = 8'd0,
    parameter bit        bits      = 1'b1
) (
    input  logic                       clk,
    input  logic                       reset,
    bus_rx_endpoint_if.slave           rx,
    output logic                       full,
    output logic [$clog2(deep_fifo):0] count,
    output logic                       ovf,
    input  logic                       clr_ovf
`ifdef BUS_RX_STATS_EN
    ,
    output logic [15:0]                rx_cnt,
    output logic [15:0]                drop_addr_cnt,
    output logic [15:0]                drop_ovf_cnt
`endif
);
    logic [ID_W-1:0]    id;
    logic               addr_match;
    logic               pop;
    logic               accept;
    logic               ovf_set;
    logic               fifo_full;
    logic               fifo_empty;
    logic [pckg_sz-1:0] fifo_rd_data;
    logic               ovf_reg;

    assign id         = pkt_id(PKT_MAX_W'(rx.D_push), pckg_sz);
    assign addr_match = (id == drvr_id) || (bits && (id == BROADCAST_ID));

    assign rx.rd_valid = ~fifo_empty;
    assign rx.rd_data  = fifo_rd_data;
    assign pop         = rx.rd_valid & rx.rd_ready;

    // A full FIFO still takes a packet when the consumer frees a slot this cycle.
    assign accept  = rx.push & addr_match & (~fifo_full | pop);
    assign ovf_set = rx.push & addr_match & fifo_full & ~pop;

    rx_sync_fifo #(
        .pckg_sz   (pckg_sz),
        .deep_fifo (deep_fifo)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (rx.push & addr_match),
        .wr_data (rx.D_push),
        .rd_en   (pop),
        .rd_data (fifo_rd_data),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (count)
    );

    assign full = fifo_full;
    assign ovf  = ovf_reg;

    // Setting wins over clearing so a drop coincident with clr_ovf is never missed.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            ovf_reg <= 1'b0;
        else if (ovf_set)
            ovf_reg <= 1'b1;
        else if (clr_ovf)
            ovf_reg <= 1'b0;
    end

`ifdef BUS_RX_STATS_EN
    logic [2:0]  stat_inc;
    logic [15:0] stat_cnt_reg [3];

    assign stat_inc = {ovf_set, rx.push & ~addr_match, accept};

    for (genvar gi = 0; gi < 3; gi++) begin : g_stat
        always_ff @(posedge clk or negedge reset) begin
            if (!reset)
                stat_cnt_reg[gi] <= '0;
            else if (stat_inc[gi]) begin
                if (clr_ovf)
                    stat_cnt_reg[gi] <= 16'd1;
                else if (stat_cnt_reg[gi] != 16'hFFFF)
                    stat_cnt_reg[gi] <= stat_cnt_reg[gi] + 16'd1;
            end else if (clr_ovf)
                stat_cnt_reg[gi] <= '0;
        end
    end

    assign rx_cnt        = stat_cnt_reg[0];
    assign drop_addr_cnt = stat_cnt_reg[1];
    assign drop_ovf_cnt  = stat_cnt_reg[2];
`else
    logic unused_accept;
    assign unused_accept = accept;
`endif
endmodule

// File: doc/bus_rx_endpoint.md
# bus_rx_endpoint

Device-side receive endpoint for the shared bus (`bs_gnrtr_n_rbtr`). It is the opposite end of the driver-side pending FIFO (pndng/pop/D_pop). The bus delivers a packet with a one-cycle `push` strobe and `D_push` data and cannot be stalled. This block address-filters each packet against its own device ID and buffers accepted packets in a FIFO. It presents them to the local consumer through a valid/ready handshake and tracks drops and overflow.

## Interface
Parameters:
- `pckg_sz`, 16: packet width in bits. The upper 8 bits are the destination ID; the lower `pckg_sz-8` bits are the payload.
- `deep_fifo`, 8: receive FIFO depth in entries. Power of two, ≥2.
- `drvr_id`, 0: this device's ID, 8 bits.
- `bits`, 1: broadcast enable. 1 means ID `8'hFF` is also accepted; 0 means only `drvr_id` is accepted.

Ports:
- `clk`  in  1  single clock, rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `push`  in  1  bus delivers `D_push` this cycle.
- `D_push`  in  pckg_sz  packet from bus.
- `rd_valid`  out  1  head entry available.
- `rd_ready`  in  1  consumer accepts the head entry.
- `rd_data`  out  pckg_sz  head packet, full word including ID.
- `full`  out  1  FIFO holds `deep_fifo` entries.
- `count`  out  $clog2(deep_fifo)+1  current occupancy.
- `ovf`  out  1  sticky: an accepted-address packet was lost because the FIFO was full.
- `clr_ovf`  in  1  synchronous clear of `ovf`.

## Operation
- Address check on every cycle where `push`=1:
  - match = (`D_push[pckg_sz-1 -: 8]` == `drvr_id`) OR (`bits`=1 AND ID == 8'hFF).
  - A non-matching packet is discarded silently. It never affects `ovf`.
- Write: a matching push writes to the FIFO if (!full) OR pop-this-cycle.
- Overflow: a matching push when full with no pop is dropped. The stored contents are unchanged (the newest packet is lost) and `ovf` is set.
- Read: show-ahead FIFO.
  - `rd_valid` = (count != 0).
  - `rd_data` = entry at the read pointer.
  - Pop = `rd_valid` & `rd_ready`.
  - `rd_ready` while empty has no effect.
- Pointers are `$clog2(deep_fifo)` bits and wrap modulo `deep_fifo`.
- `count` update per cycle: +1 on write only, −1 on pop only, unchanged on both or neither.
- Simultaneous write and pop:
  - When full: both occur; `count` stays `deep_fifo`.
  - When empty: the push is written, and no pop occurs because `rd_valid`=0 that cycle.
- `ovf` priority: a set (overflow this cycle) wins over `clr_ovf` in the same cycle.
- There is no data-dependent FSM. Control consists of the pointer/count registers plus the `ovf` flag.

## Timing
- Reset (`reset`=0, asynchronous):
  - Pointers, count and `ovf` go to 0.
  - `rd_valid`=0, `full`=0.
  - `rd_data` is don't-care; the verification bench does not check it while `rd_valid`=0.
  - FIFO memory is not reset.
- Reset asserted mid-operation empties the FIFO immediately. A push in the same cycle is lost.
- Reset release is synchronous to `clk`. The first push is accepted on the first rising edge with `reset`=1.
- Latency: a matching push at edge N gives `rd_valid`=1 and the data on `rd_data` after edge N, i.e. in cycle N+1.
- Pop takes effect at the edge where `rd_valid`&`rd_ready`=1. The next entry (or `rd_valid`=0) appears in the following cycle.
- Throughput: one push and one pop per cycle, sustained.
- `full` and `count` are registered-state derived, valid in the cycle after the causing edge.

## Configuration
- `BUS_RX_STATS_EN` defined adds three outputs:
  - `rx_cnt`, 16 bit: accepted packets.
  - `drop_addr_cnt`, 16 bit: address mismatches.
  - `drop_ovf_cnt`, 16 bit: overflow drops.
- Stats counter behaviour:
  - Counters saturate at 16'hFFFF.
  - They reset to 0 on `reset`.
  - They are cleared synchronously by `clr_ovf`; an increment in the same cycle wins and leaves the counter at 1.
- `BUS_RX_STATS_EN` undefined: these ports and counters do not exist. All other behaviour is identical.

## Structure
- `bus_pkg` holds:
  - `ID_W`=8 and `BROADCAST_ID`=8'hFF.
  - a function `pkt_id(pkt)` that extracts the ID field.
- The package is shared with the driver-side FIFO and the testbench transaction class.
- Sub-module `rx_sync_fifo`: a generic show-ahead FIFO (`pckg_sz`, `deep_fifo`) with wr_en/rd_en/full/empty/count. The top-level contains the address filter, overflow logic and stats.

## Test plan
- `drvr_id`=2: push `16'h0203` → `rd_valid`=1 next cycle, `rd_data`=`16'h0203`; `rd_ready`=1 → `rd_valid`=0 the following cycle.
- `drvr_id`=2: push `16'h0104` → never visible; `count`=0, `ovf`=0 (`drop_addr_cnt`=1 with stats).
- `bits`=1: push `16'hFF55` → accepted. `bits`=0: the same push is dropped.
- With `rd_ready`=0, push 9 matching packets `16'h0200..16'h0208` into depth 8 → `full`=1, `count`=8, `ovf`=1. Drain order: `0200` through `0207`; `0208` is lost.
- When full, push and pop in the same cycle → `count` stays 8, the pushed word appears last. `clr_ovf` plus a new overflow in the same cycle → `ovf` stays 1.
- Reset pulse with 3 entries queued → `count`=0 and `rd_valid`=0 immediately (asynchronous); a push at the first edge after release is read back correctly.
